// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types for the run/halt/step controller.
// State encoding, widths and the breakpoint compare helper.
package cpu_ctrl_pkg;

  localparam int PC_W  = 32;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    HALTED  = 2'd0,
    RUNNING = 2'd1,
    STEP    = 2'd2
  } run_state_t;

  function automatic logic bp_hit_now(
    input logic            en,
    input logic [PC_W-1:0] pc,
    input logic [PC_W-1:0] addr,
    input logic            skip
  );
    return en && (pc == addr) && !skip;
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: core-side bundle of the run controller.
// slave = controller, master = core / debug side.
interface cpu_run_controller_if;
  import cpu_ctrl_pkg::*;

  logic             halt_req;
  logic             bp_enable;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             cpu_en;
  run_state_t       run_state;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output halt_req, bp_enable, bp_addr, pc,
    input  cpu_en, run_state, bp_hit, cycle_count
  );

  modport slave (
    input  halt_req, bp_enable, bp_addr, pc,
    output cpu_en, run_state, bp_hit, cycle_count
  );

endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF sync, stable-count filter, rising pulse.
// Buttons held through reset stay masked until released once.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [1:0]    fill_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          edge_q;
  logic          armed_q;

  // Synchronizer chain plus a marker for when it holds real samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  // Accept a new level only after it differs for DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q   <= '0;
      level_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Edge register; arm only once the button is seen released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      edge_q <= level_q;
      if (fill_q[1] && !level_q && !sync_q[1])
        armed_q <= 1'b1;
    end
  end

  assign pulse = armed_q && level_q && !edge_q;

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/halt/step FSM driving the core clock-enable.
// Includes PC breakpoint, halt request and enabled-cycle counter.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit START_RUNNING   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic run_btn,
  input  logic step_btn,
  cpu_run_controller_if.slave bus
);

  localparam run_state_t RESET_STATE =
    START_RUNNING ? RUNNING : HALTED;

  logic             run_pulse;
  logic             step_pulse;
  logic             bp_match;
  logic             cpu_en;
  run_state_t       state_q, state_d;
  logic             skip_q, skip_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cycle_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk  (clk),
    .reset(reset),
    .btn  (run_btn),
    .pulse(run_pulse)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk  (clk),
    .reset(reset),
    .btn  (step_btn),
    .pulse(step_pulse)
  );

  assign bp_match = bp_hit_now(bus.bp_enable, bus.pc,
                               bus.bp_addr, skip_q);

  // Next state, clock-enable and breakpoint bookkeeping.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    hit_d   = hit_q;
    cpu_en  = 1'b0;
    unique case (state_q)
      HALTED: begin
        if (run_pulse) begin
          state_d = RUNNING;
          skip_d  = 1'b1;
          hit_d   = 1'b0;
        end else if (step_pulse) begin
          state_d = STEP;
          skip_d  = 1'b1;
        end
      end
      RUNNING: begin
        cpu_en = !bp_match && !bus.halt_req;
        if (bp_match) begin
          state_d = HALTED;
          hit_d   = 1'b1;
        end else if (bus.halt_req || run_pulse) begin
          state_d = HALTED;
        end
      end
      STEP: begin
        cpu_en  = 1'b1;
        state_d = HALTED;
      end
      default: state_d = HALTED;
    endcase
    if (cpu_en)
      skip_d = 1'b0;
  end

  // Registered state, flags and enabled-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      skip_q  <= 1'b0;
      hit_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      hit_q   <= hit_d;
      cycle_q <= cycle_q + CNT_W'(cpu_en);
    end
  end

  assign bus.cpu_en      = cpu_en;
  assign bus.run_state   = state_q;
  assign bus.bp_hit      = hit_q;
  assign bus.cycle_count = cycle_q;

endmodule
